// File: rtl/channelizer_pkg.sv
// Shared channelizer constants: FSM state encoding and default mask.
// Imported by the channel-select controller and its mask shadow.
package channelizer_pkg;

  localparam logic ST_WAIT_SYNC = 1'b0;
  localparam logic ST_RUN       = 1'b1;

  typedef enum logic {
    S_WAIT_SYNC = ST_WAIT_SYNC,
    S_RUN       = ST_RUN
  } state_e;

  localparam int unsigned      CH_N            = 8;
  localparam logic [CH_N-1:0]  CH_DEFAULT_MASK = '1;

endpackage

// File: rtl/mask_shadow.sv
// Double-buffered channel mask: pending/active/cfg_pending.
// Ports: apply, cfg_we, cfg_mask in; eff_mask, active_mask, cfg_pending out.
module mask_shadow
  import channelizer_pkg::*;
#(
  parameter int          N            = 8,
  parameter logic [N-1:0] DEFAULT_MASK = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         apply,
  input  logic         cfg_we,
  input  logic [N-1:0] cfg_mask,
  output logic [N-1:0] eff_mask,
  output logic [N-1:0] active_mask,
  output logic         cfg_pending
);

  logic [N-1:0] r_pending_mask;
  logic [N-1:0] r_active_mask;
  logic         r_pending;

  // Mask used for this cycle's keep decision; a write coincident
  // with apply bypasses the pending buffer.
  always_comb begin
    eff_mask = r_active_mask;
    if (apply) begin
      if (cfg_we)         eff_mask = cfg_mask;
      else if (r_pending) eff_mask = r_pending_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending_mask <= '0;
      r_active_mask  <= DEFAULT_MASK;
      r_pending      <= 1'b0;
    end else if (apply) begin
      r_active_mask  <= eff_mask;
      r_pending      <= 1'b0;
    end else if (cfg_we) begin
      r_pending_mask <= cfg_mask;
      r_pending      <= 1'b1;
    end
  end

  assign active_mask = r_active_mask;
  assign cfg_pending = r_pending;

endmodule

// File: rtl/channel_select_ctrl.sv
// Channel tracking, frame-alignment check, mask-based keep and tagging.
// In: sample/nd/m/first, cfg_mask/we, err_clr. Out: kept sample+tags, status.
module channel_select_ctrl
  import channelizer_pkg::*;
#(
  parameter int           N            = 8,
  parameter int           LOGN         = 3,
  parameter int           WDTH         = 32,
  parameter int           MWDTH        = 1,
  parameter logic [N-1:0] DEFAULT_MASK = {N{1'b1}},
  parameter int           FCWDTH       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WDTH-1:0]   in_data,
  input  logic              in_nd,
  input  logic [MWDTH-1:0]  in_m,
  input  logic              in_first,
  input  logic [N-1:0]      cfg_mask,
  input  logic              cfg_we,
  input  logic              err_clr,
  output logic [WDTH-1:0]   out_data,
  output logic              out_nd,
  output logic [MWDTH-1:0]  out_m,
  output logic [LOGN-1:0]   out_channel,
  output logic              out_first_kept,
  output logic              cfg_pending,
  output logic              error,
  output logic [FCWDTH-1:0] frame_count
);

  localparam logic [LOGN-1:0] LAST = LOGN'(N-1);
  localparam logic [LOGN-1:0] ONE  = LOGN'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [LOGN-1:0]   r_chan;
  logic [LOGN-1:0]   w_chan_nxt;
  logic [LOGN-1:0]   w_idx;
  logic              w_proc;
  logic              w_mis;
  logic              w_apply;
  logic              w_keep;
  logic              w_first_kept;
  logic              r_seen;
  logic [N-1:0]      w_eff_mask;
  logic [N-1:0]      w_active_mask;

  logic [WDTH-1:0]   r_out_data;
  logic              r_out_nd;
  logic [MWDTH-1:0]  r_out_m;
  logic [LOGN-1:0]   r_out_channel;
  logic              r_out_fk;
  logic              r_err;
  logic [FCWDTH-1:0] r_fc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_SYNC;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_idx       = r_chan;
    w_proc      = 1'b0;
    w_mis       = 1'b0;
    if (in_nd) begin
      unique case (r_state)
        S_WAIT_SYNC: begin
          if (in_first) begin
            w_proc      = 1'b1;
            w_idx       = '0;
            w_chan_nxt  = ONE;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (in_first) begin
            // Resync: treat as channel 0 whatever chan was.
            w_proc     = 1'b1;
            w_idx      = '0;
            w_chan_nxt = ONE;
            w_mis      = (r_chan != '0);
          end else if (r_chan == '0) begin
            w_mis       = 1'b1;
            w_state_nxt = S_WAIT_SYNC;
          end else begin
            w_proc     = 1'b1;
            w_chan_nxt = r_chan + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_apply = w_proc && (w_idx == '0);
  assign w_keep  = w_proc && w_eff_mask[w_idx];
  assign w_first_kept = w_keep && (w_apply || !r_seen);

  mask_shadow #(
    .N            (N),
    .DEFAULT_MASK (DEFAULT_MASK)
  ) u_mask (
    .clk         (clk),
    .rst_n       (rst_n),
    .apply       (w_apply),
    .cfg_we      (cfg_we),
    .cfg_mask    (cfg_mask),
    .eff_mask    (w_eff_mask),
    .active_mask (w_active_mask),
    .cfg_pending (cfg_pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data    <= '0;
      r_out_nd      <= 1'b0;
      r_out_m       <= '0;
      r_out_channel <= '0;
      r_out_fk      <= 1'b0;
      r_seen        <= 1'b0;
      r_err         <= 1'b0;
      r_fc          <= '0;
    end else begin
      r_out_nd <= w_keep;
      r_out_fk <= w_first_kept;
      if (w_keep) begin
        r_out_data    <= in_data;
        r_out_m       <= in_m;
        r_out_channel <= w_idx;
      end
      if (w_proc)
        r_seen <= w_apply ? w_keep : (r_seen | w_keep);
      r_err <= w_mis | (r_err & ~err_clr);
      if (w_proc && r_state == S_RUN && w_idx == LAST)
        r_fc <= r_fc + FCWDTH'(1);
    end
  end

  assign out_data       = r_out_data;
  assign out_nd         = r_out_nd;
  assign out_m          = r_out_m;
  assign out_channel    = r_out_channel;
  assign out_first_kept = r_out_fk;
  assign error          = r_err;
  assign frame_count    = r_fc;

endmodule

// File: tb/tb_channel_select_ctrl.sv
// Self-checking bench for channel_select_ctrl (N=8, FCWDTH=4).
// Scoreboard queue of per-cycle expectations plus a vector table.
module tb_channel_select_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_nd;
  logic        in_m;
  logic        in_first;
  logic [7:0]  cfg_mask;
  logic        cfg_we;
  logic        err_clr;
  logic [31:0] out_data;
  logic        out_nd;
  logic        out_m;
  logic [2:0]  out_channel;
  logic        out_first_kept;
  logic        cfg_pending;
  logic        error;
  logic [3:0]  frame_count;

  channel_select_ctrl #(
    .N            (8),
    .LOGN         (3),
    .WDTH         (32),
    .MWDTH        (1),
    .DEFAULT_MASK (8'hFF),
    .FCWDTH       (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_nd          (in_nd),
    .in_m           (in_m),
    .in_first       (in_first),
    .cfg_mask       (cfg_mask),
    .cfg_we         (cfg_we),
    .err_clr        (err_clr),
    .out_data       (out_data),
    .out_nd         (out_nd),
    .out_m          (out_m),
    .out_channel    (out_channel),
    .out_first_kept (out_first_kept),
    .cfg_pending    (cfg_pending),
    .error          (error),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        nd;
    logic [31:0] data;
    logic        m;
    logic [2:0]  ch;
    logic        fk;
  } exp_t;

  typedef struct {
    logic       nd;
    logic       first;
    logic       we;
    logic [7:0] mask;
    logic       clr;
    logic       e_nd;
    logic [2:0] e_ch;
    logic       e_fk;
    logic       e_err;
  } vec_t;

  exp_t q[$];
  vec_t tv[$];
  exp_t mon_e;
  int   cnt = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cnt) begin
      mon_e = q.pop_front();
      chk("out_nd", 32'(out_nd), 32'(mon_e.nd));
      if (mon_e.nd) begin
        chk("out_data", out_data, mon_e.data);
        chk("out_m", 32'(out_m), 32'(mon_e.m));
        chk("out_channel", 32'(out_channel), 32'(mon_e.ch));
        chk("out_first_kept", 32'(out_first_kept), 32'(mon_e.fk));
      end
    end
  end

  task automatic cyc(input logic nd, input logic f, input logic we,
                     input logic [7:0] mask, input logic clr,
                     input logic en, input logic [2:0] ec,
                     input logic efk);
    exp_t e;
    in_nd    = nd;
    in_first = f;
    cfg_we   = we;
    cfg_mask = mask;
    err_clr  = clr;
    in_data  = $urandom;
    in_m     = 1'($urandom);
    e.due  = cnt + 1;
    e.nd   = en;
    e.data = in_data;
    e.m    = in_m;
    e.ch   = ec;
    e.fk   = efk;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_nd    = 1'b0;
    in_first = 1'b0;
    cfg_we   = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic frames(input int n, input logic [7:0] km);
    logic [7:0] lo;
    for (int f = 0; f < n; f++)
      for (int c = 0; c < 8; c++) begin
        lo = km & ((8'd1 << c) - 8'd1);
        cyc(1'b1, c == 0, 1'b0, 8'h00, 1'b0,
            km[c], 3'(c), km[c] && lo == 8'h00);
      end
  endtask

  function automatic void addv(input logic nd, input logic f,
                               input logic we, input logic [7:0] mask,
                               input logic clr, input logic en,
                               input logic [2:0] ec, input logic efk,
                               input logic eerr);
    vec_t v;
    v.nd = nd; v.first = f; v.we = we; v.mask = mask; v.clr = clr;
    v.e_nd = en; v.e_ch = ec; v.e_fk = efk; v.e_err = eerr;
    tv.push_back(v);
  endfunction

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_out_nd"}, 32'(out_nd), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_m"}, 32'(out_m), 32'd0);
    chk({tag, "_out_channel"}, 32'(out_channel), 32'd0);
    chk({tag, "_out_fk"}, 32'(out_first_kept), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_cfg_pending"}, 32'(cfg_pending), 32'd0);
  endtask

  initial begin
    // misalignment / error-clear table, starting at chan 0 in RUN
    addv(1,1,1,8'hFF,0, 1,0,1, 0);
    addv(1,0,0,8'h00,0, 1,1,0, 0);
    addv(1,0,0,8'h00,0, 1,2,0, 0);
    addv(1,1,0,8'h00,0, 1,0,1, 1);
    addv(1,0,0,8'h00,0, 1,1,0, 1);
    for (int c = 2; c < 8; c++)
      addv(1,0,0,8'h00,0, 1,3'(c),0, 1);
    addv(1,0,0,8'h00,0, 0,0,0, 1);
    addv(1,0,0,8'h00,0, 0,0,0, 1);
    addv(0,0,0,8'h00,0, 0,0,0, 1);
    addv(1,1,0,8'h00,0, 1,0,1, 1);
    for (int c = 1; c < 8; c++)
      addv(1,0,0,8'h00,0, 1,3'(c),0, 1);
    addv(0,0,0,8'h00,1, 0,0,0, 0);
    addv(1,1,0,8'h00,0, 1,0,1, 0);
    addv(1,0,0,8'h00,0, 1,1,0, 0);
    addv(0,0,0,8'h00,0, 0,0,0, 0);
    addv(1,1,0,8'h00,1, 1,0,1, 1);
    addv(1,0,0,8'h00,0, 1,1,0, 1);
    addv(0,0,0,8'h00,1, 0,0,0, 0);

    rst_n = 1'b0;
    in_data = '0; in_nd = 0; in_m = 0; in_first = 0;
    cfg_mask = '0; cfg_we = 0; err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("rst");
    rst_n = 1'b1;

    // basic sync: drops before first, then 3 full frames
    for (int i = 0; i < 3; i++) cyc(1,0,0,8'h00,0, 0,0,0);
    frames(3, 8'hFF);
    chk("basic_frame_count", 32'(frame_count), 32'd3);
    chk("basic_error", 32'(error), 32'd0);

    // mask apply mid-frame
    for (int c = 0; c < 8; c++) begin
      cyc(1, c == 0, c == 4, 8'h05, 0, 1, 3'(c), c == 0);
      if (c == 4) chk("apply_pending_set", 32'(cfg_pending), 32'd1);
    end
    chk("apply_pending_hold", 32'(cfg_pending), 32'd1);
    cyc(1,1,0,8'h00,0, 1,0,1);
    chk("apply_pending_clr", 32'(cfg_pending), 32'd0);
    for (int c = 1; c < 8; c++) cyc(1,0,0,8'h00,0, c == 2, 3'(c), 0);
    frames(1, 8'h05);
    chk("apply_frame_count", 32'(frame_count), 32'd6);

    // coincident write while 0xFF is pending
    for (int c = 0; c < 8; c++)
      cyc(1, c == 0, c == 3, 8'hFF, 0, c == 0 || c == 2, 3'(c), c == 0);
    chk("coin_pending_pre", 32'(cfg_pending), 32'd1);
    cyc(1,1,1,8'h80,0, 0,0,0);
    chk("coin_pending_post", 32'(cfg_pending), 32'd0);
    for (int c = 1; c < 8; c++) cyc(1,0,0,8'h00,0, c == 7, 3'(c), c == 7);
    frames(1, 8'h80);
    chk("coin_frame_count", 32'(frame_count), 32'd9);

    // misalignment, drop/resync, err_clr table
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].nd, tv[i].first, tv[i].we, tv[i].mask, tv[i].clr,
          tv[i].e_nd, tv[i].e_ch, tv[i].e_fk);
      chk($sformatf("tv%0d_error", i), 32'(error), 32'(tv[i].e_err));
    end
    for (int c = 2; c < 8; c++) cyc(1,0,0,8'h00,0, 1, 3'(c), 0);
    chk("mis_frame_count", 32'(frame_count), 32'd12);

    // reset mid-frame at chan 5 with 0x0F pending
    for (int c = 0; c < 5; c++)
      cyc(1, c == 0, c == 2, 8'h0F, 0, 1, 3'(c), c == 0);
    chk("rstmid_pending_pre", 32'(cfg_pending), 32'd1);
    cyc(0,0,0,8'h00,0, 0,0,0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("rstmid");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1,0,0,8'h00,0, 0,0,0);
    cyc(1,0,0,8'h00,0, 0,0,0);
    // all channels kept proves default mask and discarded pending
    frames(17, 8'hFF);
    chk("wrap_frame_count", 32'(frame_count), 32'd1);
    chk("wrap_pending", 32'(cfg_pending), 32'd0);
    chk("wrap_error", 32'(error), 32'd0);
    cyc(0,0,0,8'h00,0, 0,0,0);
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
